// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes over valid/ready and shifts out start/data/parity/stop.
// Define UART_TX_BREAK_EN to add the tx_break input (line break plus one mark bit on release).
module uart_tx_serializer #(
  parameter int unsigned DATA_W     = 8,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cr_pbit,
  input  logic              cr_ptype,
  input  logic [1:0]        cr_sbit,
  input  logic [31:0]       cr_baud_limit,
  input  logic              cr_baud_update,
  input  logic              cr_tx_en,
`ifdef UART_TX_BREAK_EN
  input  logic              tx_break,
`endif
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned CntW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
`ifdef UART_TX_BREAK_EN
    ,
    StBreak,
    StMark
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         baud_cnt_q, baud_cnt_d;
  logic [31:0]         baud_lat_q, baud_lat_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]          stop_cnt_q, stop_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                pbit_lat_q, pbit_lat_d;
  logic                par_q, par_d;
  logic [1:0]          sbit_lat_q, sbit_lat_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;

  logic                bit_end;
  logic                accept;
  logic                break_req;
  logic [1:0]          stop_max;

  // The baud limit is re-sampled on every accept, so the update strobe carries no extra information.
  logic unused_baud_update;
  assign unused_baud_update = cr_baud_update;

`ifdef UART_TX_BREAK_EN
  assign break_req = tx_break;
`else
  assign break_req = 1'b0;
`endif

  assign bit_end  = (baud_cnt_q == baud_lat_q);
  assign accept   = s_valid && s_ready;
  assign stop_max = (sbit_lat_q == 2'b00) ? 2'd0 : (sbit_lat_q == 2'b01) ? 2'd1 : 2'd2;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      baud_lat_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      shift_q    <= '0;
      pbit_lat_q <= 1'b0;
      par_q      <= 1'b0;
      sbit_lat_q <= 2'b00;
      tx_q       <= IDLE_LEVEL;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      baud_lat_q <= baud_lat_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      pbit_lat_q <= pbit_lat_d;
      par_q      <= par_d;
      sbit_lat_q <= sbit_lat_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = bit_end ? '0 : baud_cnt_q + 32'd1;
    baud_lat_d = baud_lat_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    pbit_lat_d = pbit_lat_q;
    par_d      = par_q;
    sbit_lat_d = sbit_lat_q;

    unique case (state_q)
      StIdle: begin
        baud_cnt_d = '0;
        if (accept) begin
          state_d    = StStart;
          shift_d    = s_data;
          pbit_lat_d = cr_pbit;
          par_d      = (^s_data) ^ cr_ptype;
          sbit_lat_d = cr_sbit;
          baud_lat_d = cr_baud_limit;
          bit_cnt_d  = '0;
          stop_cnt_d = '0;
        end
`ifdef UART_TX_BREAK_EN
        else if (tx_break) begin
          state_d    = StBreak;
          baud_lat_d = cr_baud_limit;
        end
`endif
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == CntW'(DATA_W - 1)) begin
            state_d = pbit_lat_q ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          stop_cnt_d = stop_cnt_q + 2'd1;
          if (stop_cnt_q == stop_max) state_d = StIdle;
        end
      end
`ifdef UART_TX_BREAK_EN
      StBreak: begin
        baud_cnt_d = '0;
        if (!tx_break) state_d = StMark;
      end
      StMark: begin
        if (bit_end) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs; tx is computed from the next state so the pin is a plain register.
  always_comb begin
    s_ready = reset_n && (state_q == StIdle) && cr_tx_en && !break_req;
    busy_o  = state_q inside {StStart, StData, StParity, StStop};
    done_d  = (state_q == StStop) && (state_d == StIdle);
    tx_d    = IDLE_LEVEL;
    unique case (state_d)
      StIdle:   tx_d = IDLE_LEVEL;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_q;
      StStop:   tx_d = IDLE_LEVEL;
`ifdef UART_TX_BREAK_EN
      StBreak:  tx_d = 1'b0;
      StMark:   tx_d = IDLE_LEVEL;
`endif
      default:  tx_d = IDLE_LEVEL;
    endcase
  end

  assign tx_o   = tx_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: frame-level waveform model plus directed literal checks.
module tb_uart_tx_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cr_pbit, cr_ptype;
  logic [1:0]  cr_sbit;
  logic [31:0] cr_baud_limit;
  logic        cr_baud_update;
  logic        cr_tx_en;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready, tx_o, busy_o, done_o;
`ifdef UART_TX_BREAK_EN
  logic        tx_break;
`endif

  always #5 clk = ~clk;

  uart_tx_serializer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cr_pbit        (cr_pbit),
    .cr_ptype       (cr_ptype),
    .cr_sbit        (cr_sbit),
    .cr_baud_limit  (cr_baud_limit),
    .cr_baud_update (cr_baud_update),
    .cr_tx_en       (cr_tx_en),
`ifdef UART_TX_BREAK_EN
    .tx_break       (tx_break),
`endif
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .tx_o           (tx_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: each accepted byte expands into the per-clock line levels of its whole frame.
  logic        q[$];
  bit          brk = 0;
  int          mark_left = 0;
  logic [31:0] brk_bl = '0;
  bit          m_done = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    bit   idle, was_busy, brk_go, bv;
    int   nstop, nbits;
    if (!reset_n) begin
      q.delete();
      m_done    = 0;
      brk       = 0;
      mark_left = 0;
    end else begin
      idle     = (q.size() == 0) && !brk && (mark_left == 0);
      was_busy = (q.size() != 0);
      m_done   = 0;
      if (was_busy) begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1;
      end
      if (mark_left > 0) mark_left--;
`ifdef UART_TX_BREAK_EN
      if (brk && !tx_break) begin
        brk       = 0;
        mark_left = int'(brk_bl) + 1;
      end
`endif
      if (idle) begin
        brk_go = 0;
`ifdef UART_TX_BREAK_EN
        brk_go = tx_break;
`endif
        if (brk_go) begin
          brk    = 1;
          brk_bl = cr_baud_limit;
        end else if (cr_tx_en && s_valid) begin
          nstop = (cr_sbit == 2'b00) ? 1 : (cr_sbit == 2'b01) ? 2 : 3;
          nbits = 9 + (cr_pbit ? 1 : 0) + nstop;
          for (int i = 0; i < nbits; i++) begin
            if (i == 0) bv = 0;
            else if (i <= 8) bv = s_data[i-1];
            else if (cr_pbit && i == 9) bv = (^s_data) ^ cr_ptype;
            else bv = 1;
            repeat (int'(cr_baud_limit) + 1) q.push_back(bv);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic e_tx, e_ready;
    if (chk_en) begin
      e_ready = reset_n && (q.size() == 0) && !brk && (mark_left == 0) && cr_tx_en;
`ifdef UART_TX_BREAK_EN
      e_ready = e_ready && !tx_break;
`endif
      e_tx = (q.size() != 0) ? q[0] : (brk ? 1'b0 : 1'b1);
      check("model_tx_o", 32'(tx_o), 32'(e_tx));
      check("model_busy_o", 32'(busy_o), 32'(q.size() != 0));
      check("model_s_ready", 32'(s_ready), 32'(e_ready));
      check("model_done_o", 32'(done_o), 32'(m_done));
    end
  end

  int   t0;
  logic cap[0:255];
  int   flen;
  int   ones;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Lands on the falling edge of cycle t0+k.
  task automatic goto_cyc(input int k);
    while (int'(cyc) < t0 + k) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic start_byte(input logic [7:0] d);
    s_data  = d;
    s_valid = 1'b1;
    t0      = int'(cyc);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] d, input bit mid_write);
    start_byte(d);
    flen = 0;
    @(negedge clk);
    while (busy_o === 1'b1 && flen < 256) begin
      cap[flen] = tx_o;
      flen++;
      if (mid_write && flen == 5) begin
        cr_baud_limit  = 32'd1;
        cr_baud_update = 1'b1;
      end
      if (mid_write && flen == 6) cr_baud_update = 1'b0;
      @(negedge clk);
    end
    check("done_after_frame", 32'(done_o), 32'd1);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    cr_pbit        = 1'b0;
    cr_ptype       = 1'b0;
    cr_sbit        = 2'b00;
    cr_baud_limit  = 32'd3;
    cr_baud_update = 1'b0;
    cr_tx_en       = 1'b1;
    s_data         = 8'h00;
    s_valid        = 1'b0;
`ifdef UART_TX_BREAK_EN
    tx_break       = 1'b0;
`endif
    repeat (2) tick();
    chk_en = 1;
    @(negedge clk);
    check("reset_tx_o", 32'(tx_o), 32'd1);
    check("reset_busy_o", 32'(busy_o), 32'd0);
    check("reset_s_ready", 32'(s_ready), 32'd0);
    check("reset_done_o", 32'(done_o), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Basic frame 0x55 at 4 clk per bit.
    start_byte(8'h55);
    goto_cyc(1);  check("basic_start_c1", 32'(tx_o), 32'd0);
    goto_cyc(4);  check("basic_start_c4", 32'(tx_o), 32'd0);
    goto_cyc(5);  check("basic_d0", 32'(tx_o), 32'd1);
    goto_cyc(9);  check("basic_d1", 32'(tx_o), 32'd0);
    goto_cyc(36); check("basic_d7", 32'(tx_o), 32'd0);
    goto_cyc(37); check("basic_stop_c37", 32'(tx_o), 32'd1);
    goto_cyc(40); check("basic_busy_c40", 32'(busy_o), 32'd1);
    goto_cyc(41);
    check("basic_done_c41", 32'(done_o), 32'd1);
    check("basic_ready_c41", 32'(s_ready), 32'd1);
    goto_cyc(42); check("basic_done_c42", 32'(done_o), 32'd0);
    tick();

    // Parity even / odd.
    cr_baud_limit = 32'd0;
    cr_pbit       = 1'b1;
    cr_ptype      = 1'b0;
    run_frame(8'h07, 0);
    check("par_even_len", 32'(flen), 32'd11);
    check("par_even_bit", 32'(cap[9]), 32'd1);
    cr_ptype = 1'b1;
    run_frame(8'h07, 0);
    check("par_odd_len", 32'(flen), 32'd11);
    check("par_odd_bit", 32'(cap[9]), 32'd0);

    // Stop bits.
    cr_pbit       = 1'b0;
    cr_ptype      = 1'b0;
    cr_sbit       = 2'b11;
    cr_baud_limit = 32'd1;
    run_frame(8'hFF, 0);
    check("stop3_len", 32'(flen), 32'd24);
    check("stop3_start", 32'({cap[0], cap[1]}), 32'd0);
    ones = 0;
    for (int i = 2; i < flen; i++) if (cap[i] === 1'b1) ones++;
    check("stop3_high", 32'(ones), 32'd22);
    cr_sbit = 2'b01;
    run_frame(8'hFF, 0);
    check("stop2_len", 32'(flen), 32'd22);

    // Baud change in flight must not touch the current frame.
    cr_sbit       = 2'b00;
    cr_baud_limit = 32'd9;
    run_frame(8'hA5, 1);
    check("midcfg_len", 32'(flen), 32'd100);
    check("midcfg_start_end", 32'(cap[9]), 32'd0);
    check("midcfg_d0", 32'(cap[10]), 32'd1);
    run_frame(8'hA5, 0);
    check("midcfg_next_len", 32'(flen), 32'd20);

    // Back-to-back frames; data is sampled only on accept.
    cr_baud_limit = 32'd0;
    s_data  = 8'h3C;
    s_valid = 1'b1;
    t0      = int'(cyc);
    repeat (5) tick();
    s_data = 8'hC3;
    goto_cyc(11);
    check("b2b_gap_tx", 32'(tx_o), 32'd1);
    check("b2b_gap_ready", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    goto_cyc(12); check("b2b_start", 32'(tx_o), 32'd0);
    goto_cyc(13); check("b2b_d0", 32'(tx_o), 32'd1);
    goto_cyc(22); check("b2b_done", 32'(done_o), 32'd1);
    tick();

    // Enable dropped mid-frame: frame completes, no further accept.
    start_byte(8'h81);
    cr_tx_en = 1'b0;
    s_valid  = 1'b1;
    goto_cyc(11);
    check("txen_done", 32'(done_o), 32'd1);
    check("txen_ready", 32'(s_ready), 32'd0);
    goto_cyc(15); check("txen_idle", 32'(busy_o), 32'd0);
    tick();
    s_valid  = 1'b0;
    cr_tx_en = 1'b1;

    // Reset during data bit 3.
    cr_baud_limit = 32'd3;
    start_byte(8'h55);
    goto_cyc(18);
    tick();
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    check("rst_mid_tx", 32'(tx_o), 32'd1);
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_ready", 32'(s_ready), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    cr_tx_en = 1'b0;
    s_valid  = 1'b1;
    s_data   = 8'hEE;
    repeat (10) tick();
    @(negedge clk);
    check("dis_busy", 32'(busy_o), 32'd0);
    check("dis_ready", 32'(s_ready), 32'd0);
    tick();
    s_valid  = 1'b0;
    cr_tx_en = 1'b1;

`ifdef UART_TX_BREAK_EN
    // Break for 20 clks, then one 5-clk mark bit.
    cr_baud_limit = 32'd4;
    tick();
    tx_break = 1'b1;
    t0       = int'(cyc);
    goto_cyc(1);
    check("brk_tx_c1", 32'(tx_o), 32'd0);
    check("brk_ready_c1", 32'(s_ready), 32'd0);
    goto_cyc(19);
    tick();
    tx_break = 1'b0;
    goto_cyc(20); check("brk_tx_c20", 32'(tx_o), 32'd0);
    goto_cyc(21);
    check("mark_tx_c21", 32'(tx_o), 32'd1);
    check("mark_ready_c21", 32'(s_ready), 32'd0);
    goto_cyc(25);
    check("mark_tx_c25", 32'(tx_o), 32'd1);
    check("mark_ready_c25", 32'(s_ready), 32'd0);
    goto_cyc(26); check("mark_ready_c26", 32'(s_ready), 32'd1);
    tick();
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit line stage sitting directly downstream of the register/CSR block and the TX FIFO.
- Pops bytes from the TX FIFO over a valid/ready handshake and serializes each byte onto the UART TX pin as a frame: start bit, 8 data bits LSB first, optional parity, and 1–3 stop bits.
- Bit timing comes from an internal baud counter driven by the CSR baud limit. Frame format comes from the CSR control bits.

Parameters:
- DATA_W, 8, data bits per frame; only 8 is supported.
- IDLE_LEVEL, 1, line level while idle and during stop bits.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low
- cr_pbit  in  1  parity enable
- cr_ptype  in  1  parity type: 0 = even, 1 = odd
- cr_sbit  in  2  stop bits: 00 = 1, 01 = 2, 10 = 3, 11 = 3
- cr_baud_limit  in  32  bit period minus one, in clk cycles
- cr_baud_update  in  1  one-cycle pulse: new baud limit written
- cr_tx_en  in  1  transmitter enable
- s_data  in  8  byte from TX FIFO
- s_valid  in  1  TX FIFO not empty
- s_ready  out  1  byte accepted (FIFO pop) when s_valid && s_ready
- tx_o  out  1  serial output line
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle pulse at end of frame

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on reset_n. All state is sampled on posedge clk while reset_n = 0.
- Reset values:
  - tx_o = IDLE_LEVEL, s_ready = 0, busy_o = 0, done_o = 0.
  - FSM = IDLE; baud counter, bit counter and stop counter = 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- s_ready is combinational: (state == IDLE) && cr_tx_en.
- Accept: on valid && ready in IDLE, the block latches:
  - s_data into the shift register;
  - cr_pbit, cr_ptype, cr_sbit and cr_baud_limit into frame-local copies;
  - then goes to START on the next edge.
- Config stability: CSR changes, including cr_baud_update, never affect a frame in flight. New values apply from the next accept.
- Bit period: baud_lat + 1 clk cycles. The baud counter counts 0..baud_lat, and a bit ends when the counter equals baud_lat. baud_lat = 0 gives one clk per bit. The compare is full 32-bit unsigned; no overflow is possible because the counter resets at the compare.
- tx_o per state:
  - START: 0.
  - DATA: shift[0], shifting right at each bit end; bit counter runs 0..7.
  - PARITY: entered only if pbit_lat; drives XOR of the data byte, inverted when ptype_lat = 1.
  - STOP: IDLE_LEVEL for N = 1/2/3/3 bit periods per sbit_lat.
- Transitions:
  - START → DATA.
  - DATA after bit 7 → PARITY if pbit_lat, else STOP.
  - PARITY → STOP.
  - STOP after N periods → IDLE.
- tx_o is registered, with no combinational path from inputs.
- busy_o = 1 in every state except IDLE.
- done_o pulses in the cycle the FSM enters IDLE.
- Frame spacing: s_ready is high earliest one cycle after the last stop-bit cycle. Back-to-back frames therefore have a final stop bit stretched by exactly one clk, or more if s_valid stays low.
- Frame length in clocks: (1 + 8 + pbit + N) × (baud_lat + 1).
- cr_tx_en deasserted mid-frame: the current frame completes normally, and no further byte is accepted.
- Reset asserted mid-frame: on the next edge tx_o = IDLE_LEVEL and FSM = IDLE. The partially sent byte is lost and the FIFO is not re-popped.
- s_valid dropping while not ready: no effect.
- s_data is sampled only on the accept cycle.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- With the macro defined:
  - Extra input tx_break (1 bit).
  - While tx_break = 1 and FSM = IDLE: tx_o = 0 and s_ready = 0.
  - tx_break asserted mid-frame takes effect only after that frame ends.
  - On release, tx_o = 1 for baud_lat + 1 clocks (mark-after-break; baud_lat is re-latched from cr_baud_limit at break entry), and s_ready stays 0 during that time.
- Without the macro: the port does not exist, and no break logic is present.

Test Plan:
- Basic frame: baud_limit = 3, pbit = 0, sbit = 00, push 0x55 with accept at cycle 0.
  → tx_o is 0 for cycles 1–4, then alternates 1,0,1,0,1,0,1,0 in 4-clk bits (cycles 5–36), then 1 for cycles 37–40.
  → done_o is high at cycle 41 and s_ready is high at cycle 41.
- Parity: baud_limit = 0, pbit = 1, push 0x07.
  → With ptype = 0 the parity bit is 1; with ptype = 1 it is 0.
  → Frame is 11 clks for 1 stop bit.
- Stop bits: sbit = 11, baud_limit = 1, pbit = 0, push 0xFF.
  → Frame is 2 × 12 = 24 clks: one low start bit, then tx_o high for 22 clks.
  → sbit = 01 gives 22 clks.
- Mid-frame config: during a 0xA5 frame at baud_limit = 9, write cr_baud_limit = 1 with cr_baud_update.
  → The current frame keeps 10-clk bits.
  → The next frame uses 2-clk bits.
- Reset and enable: assert reset_n = 0 at DATA bit 3.
  → tx_o = 1, busy_o = 0 and s_ready = 0 after the edge.
  → With cr_tx_en = 0 and s_valid = 1, no accept occurs.
- Break (UART_TX_BREAK_EN): hold tx_break for 20 clks with baud_limit = 4.
  → tx_o = 0 for 20 clks, then 1 for 5 clks with s_ready = 0, then s_ready = 1.
